// File: rtl/uart_display_pkg.sv
// Shared constants and types for the UART-to-display loader.
// Imported by the decoder and the loader top.
package uart_display_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    localparam int DEFAULT_TIMEOUT_CYCLES = 10_000_000;

    typedef enum logic {
        IDLE,
        COLLECT
    } load_state_t;

endpackage

// File: rtl/uart_hex_display_loader_if.sv
// Byte/CPU input bundle and display-word outputs of the loader.
// master drives bytes and writes; slave is the loader.
interface uart_hex_display_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] data;
    logic        data_updated;
    logic        err;
    logic [3:0]  digit_count;

    modport master (
        output rx_data,
        output rx_valid,
        output wr_en,
        output wr_data,
        input  data,
        input  data_updated,
        input  err,
        input  digit_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  wr_en,
        input  wr_data,
        output data,
        output data_updated,
        output err,
        output digit_count
    );

endinterface

// File: rtl/ascii_hex_decoder.sv
// Classifies one received byte: hex digit (with value),
// line terminator, escape, or anything else.
module ascii_hex_decoder
    import uart_display_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic       is_term,
    output logic       is_esc
);

    always_comb begin
        is_hex  = 1'b0;
        nibble  = 4'h0;
        is_term = 1'b0;
        is_esc  = 1'b0;
        unique case (1'b1)
            (rx_data inside {[8'h30:8'h39]}): begin
                is_hex = 1'b1;
                nibble = rx_data[3:0];
            end
            // 'A'..'F' and 'a'..'f' share low bits 1..6
            (rx_data inside {[8'h41:8'h46]}),
            (rx_data inside {[8'h61:8'h66]}): begin
                is_hex = 1'b1;
                nibble = rx_data[3:0] + 4'd9;
            end
            (rx_data == ASCII_CR),
            (rx_data == ASCII_LF): begin
                is_term = 1'b1;
            end
            (rx_data == ASCII_ESC): begin
                is_esc = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/uart_hex_display_loader.sv
// Parses ASCII hex from the UART into a 32-bit display word;
// a CPU write loads the word directly and wins over UART input.
module uart_hex_display_loader
    import uart_display_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk_100MHz,
    input  logic                     rst_n,
    uart_hex_display_loader_if.slave bus
);

    localparam int TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    D_MAX  = 4'(DIGITS);

    load_state_t   state, state_nxt;
    logic [31:0]   shadow, shadow_nxt;
    logic [3:0]    count, count_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [31:0]   data_q, data_nxt;
    logic          upd_q, upd_nxt;
    logic          err_q, err_nxt;
    logic          abort;

    logic       is_hex;
    logic [3:0] nibble;
    logic       is_term;
    logic       is_esc;

    ascii_hex_decoder u_dec (
        .rx_data (bus.rx_data),
        .is_hex  (is_hex),
        .nibble  (nibble),
        .is_term (is_term),
        .is_esc  (is_esc)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            count  <= '0;
            timer  <= '0;
            data_q <= '0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            count  <= count_nxt;
            timer  <= timer_nxt;
            data_q <= data_nxt;
            upd_q  <= upd_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        count_nxt  = count;
        data_nxt   = data_q;
        upd_nxt    = 1'b0;
        err_nxt    = 1'b0;
        abort      = 1'b0;
        timer_nxt  = (state == COLLECT) ? timer + 1'b1 : '0;

        if (bus.wr_en) begin
            // any byte arriving with the write is dropped silently
            data_nxt = bus.wr_data;
            upd_nxt  = 1'b1;
            abort    = 1'b1;
        end else if (bus.rx_valid) begin
            timer_nxt = '0;
            unique case (1'b1)
                is_hex: begin
                    if (count < D_MAX) begin
                        shadow_nxt = {shadow[27:0], nibble};
                        count_nxt  = count + 4'd1;
                        state_nxt  = COLLECT;
                    end else begin
                        err_nxt = 1'b1;
                        abort   = 1'b1;
                    end
                end
                is_term: begin
                    if (state == COLLECT) begin
                        data_nxt = shadow;
                        upd_nxt  = 1'b1;
                        abort    = 1'b1;
                    end
                end
                is_esc: begin
                    abort = 1'b1;
                end
                default: begin
                    err_nxt = 1'b1;
                    abort   = 1'b1;
                end
            endcase
        end else if (state == COLLECT && timer == T_LAST) begin
            err_nxt = 1'b1;
            abort   = 1'b1;
        end

        if (abort) begin
            state_nxt  = IDLE;
            shadow_nxt = '0;
            count_nxt  = '0;
            timer_nxt  = '0;
        end
    end

    assign bus.data         = data_q;
    assign bus.data_updated = upd_q;
    assign bus.err          = err_q;
    assign bus.digit_count  = count;

endmodule

// File: tb/tb_uart_hex_display_loader.sv
// Randomized byte/write stimulus checked cycle by cycle
// against a character-level model of the loader.
module tb_uart_hex_display_loader;

    localparam int T   = 100;
    localparam int DIG = 8;

    logic clk_100MHz = 1'b0;
    logic rst_n      = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_hex_display_loader_if bus ();

    uart_hex_display_loader #(
        .DIGITS         (DIG),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .bus        (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_data;
    logic [31:0] m_acc;
    int          m_n;
    int          m_idle;
    bit          m_upd;
    bit          m_err;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc  = '0;
        m_n    = 0;
        m_idle = 0;
    endtask

    task automatic model_rst();
        model_clear();
        m_data = '0;
        m_upd  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_eval(bit v, logic [7:0] b, bit w,
                              logic [31:0] wd);
        int val;
        val   = -1;
        m_upd = 1'b0;
        m_err = 1'b0;
        if (w) begin
            m_data = wd;
            m_upd  = 1'b1;
            model_clear();
        end else if (v) begin
            m_idle = 0;
            if (b >= 8'h30 && b <= 8'h39) val = int'(b) - 48;
            else if (b >= 8'h41 && b <= 8'h46) val = int'(b) - 55;
            else if (b >= 8'h61 && b <= 8'h66) val = int'(b) - 87;
            if (val >= 0) begin
                if (m_n < DIG) begin
                    m_acc = m_acc * 32'd16 + 32'(val);
                    m_n++;
                end else begin
                    m_err = 1'b1;
                    model_clear();
                end
            end else if (b == 8'h0D || b == 8'h0A) begin
                if (m_n > 0) begin
                    m_data = m_acc;
                    m_upd  = 1'b1;
                    model_clear();
                end
            end else if (b == 8'h1B) begin
                model_clear();
            end else begin
                m_err = 1'b1;
                model_clear();
            end
        end else if (m_n > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_err = 1'b1;
                model_clear();
            end
        end
    endtask

    task automatic step(bit v, logic [7:0] b, bit w,
                        logic [31:0] wd);
        @(negedge clk_100MHz);
        bus.rx_valid = v;
        bus.rx_data  = b;
        bus.wr_en    = w;
        bus.wr_data  = wd;
        model_eval(v, b, w, wd);
        @(posedge clk_100MHz);
        #1;
        chk("data", bus.data, m_data);
        chk("data_updated", 32'(bus.data_updated), 32'(m_upd));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("digit_count", 32'(bus.digit_count), 32'(m_n));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, '0);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++)
            step(1'b1, s[i], 1'b0, '0);
    endtask

    function automatic logic [7:0] hex_char(int v, bit lower);
        if (v < 10) return 8'(48 + v);
        return lower ? 8'(87 + v) : 8'(55 + v);
    endfunction

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        model_rst();
        #1;
        chk("rst_data", bus.data, 32'h0);
        chk("rst_upd", 32'(bus.data_updated), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_cnt", 32'(bus.digit_count), 32'h0);
        repeat (2) @(negedge clk_100MHz);
        rst_n = 1'b1;

        send_str("1A2b");
        step(1'b1, 8'h0D, 1'b0, '0);
        chk("tp_1a2b", bus.data, 32'h00001A2B);
        step(1'b1, 8'h0A, 1'b0, '0);
        chk("tp_lf_no_pulse", 32'(bus.data_updated), 32'h0);

        send_str("DEADBEEF");
        step(1'b1, 8'h0A, 1'b0, '0);
        chk("tp_deadbeef", bus.data, 32'hDEADBEEF);
        send_str("123456789");
        chk("tp_ovf_err", 32'(bus.err), 32'h1);
        chk("tp_ovf_data", bus.data, 32'hDEADBEEF);
        chk("tp_ovf_cnt", 32'(bus.digit_count), 32'h0);
        idle(2);

        send_str("12G");
        chk("tp_bad_err", 32'(bus.err), 32'h1);
        send_str("3");
        step(1'b1, 8'h0D, 1'b0, '0);
        chk("tp_after_bad", bus.data, 32'h00000003);

        send_str("5");
        idle(T + 3);
        chk("tp_to_cnt", 32'(bus.digit_count), 32'h0);
        step(1'b1, 8'h0D, 1'b0, '0);
        chk("tp_to_no_upd", 32'(bus.data_updated), 32'h0);
        chk("tp_to_data", bus.data, 32'h00000003);

        send_str("77");
        step(1'b1, 8'h0D, 1'b1, 32'hCAFEF00D);
        chk("tp_wr_data", bus.data, 32'hCAFEF00D);
        chk("tp_wr_err", 32'(bus.err), 32'h0);
        idle(2);

        send_str("AB");
        @(negedge clk_100MHz);
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_rst();
        chk("arst_data", bus.data, 32'h0);
        chk("arst_upd", 32'(bus.data_updated), 32'h0);
        chk("arst_err", 32'(bus.err), 32'h0);
        chk("arst_cnt", 32'(bus.digit_count), 32'h0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        send_str("C");
        step(1'b1, 8'h0D, 1'b0, '0);
        chk("tp_after_rst", bus.data, 32'h0000000C);

        for (int k = 0; k < 2500; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55)
                step(1'b1, hex_char(int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1))), 1'b0, '0);
            else if (r < 68)
                step(1'b1, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A,
                     1'b0, '0);
            else if (r < 71)
                step(1'b1, 8'h1B, 1'b0, '0);
            else if (r < 78)
                step(1'b1, 8'($urandom_range(0, 255)), 1'b0, '0);
            else if (r < 90)
                idle(int'($urandom_range(1, 3)));
            else if (r < 97)
                step(1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 1'b1, $urandom);
            else
                idle(T - 2 + int'($urandom_range(0, 6)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
